// File: rtl/threshold_stream.sv
// rtl/threshold_stream.sv - streaming per-pixel threshold with frame markers and previous-frame mean
module threshold_stream #(
    parameter int PIX_W = 8,
    parameter int IMG_W = 128,
    parameter int IMG_H = 32,
    parameter int LOG_N = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       cfg_mode,
    input  logic [PIX_W-1:0] cfg_thresh,
    input  logic             cfg_auto,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [PIX_W-1:0] s_pixel,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [PIX_W-1:0] m_data,
    output logic             m_bit,
    output logic             m_first,
    output logic             m_last,
    output logic [PIX_W-1:0] mean,
    output logic             mean_vld
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int SW = PIX_W + LOG_N;

    localparam logic [1:0] MODE_BINARY     = 2'd0;
    localparam logic [1:0] MODE_BINARY_INV = 2'd1;
    localparam logic [1:0] MODE_TOZERO     = 2'd2;

    logic [CW-1:0]    r_col;
    logic [RW-1:0]    r_row;
    logic [SW-1:0]    r_sum;
    logic [PIX_W-1:0] r_mean;
    logic             r_mean_vld;
    logic [1:0]       r_mode;
    logic [PIX_W-1:0] r_thresh;
    logic             r_auto;

    logic             r_m_valid;
    logic [PIX_W-1:0] r_m_data;
    logic             r_m_bit;
    logic             r_m_first;
    logic             r_m_last;

    logic             w_accept;
    logic             w_first;
    logic             w_col_end;
    logic             w_last;
    logic [1:0]       w_mode;
    logic [PIX_W-1:0] w_thresh;
    logic             w_auto;
    logic [PIX_W-1:0] w_th;
    logic             w_gt;
    logic [PIX_W-1:0] w_data;
    logic [SW-1:0]    w_sum_next;

    assign s_ready   = !r_m_valid || m_ready;
    assign w_accept  = s_valid && s_ready;
    assign w_first   = (r_col == '0) && (r_row == '0);
    assign w_col_end = (r_col == CW'(IMG_W - 1));
    assign w_last    = w_col_end && (r_row == RW'(IMG_H - 1));

    // Pixel (0,0) is thresholded with the config being latched on that same accept.
    assign w_mode   = w_first ? cfg_mode   : r_mode;
    assign w_thresh = w_first ? cfg_thresh : r_thresh;
    assign w_auto   = w_first ? cfg_auto   : r_auto;

    assign w_th       = (w_auto && r_mean_vld) ? r_mean : w_thresh;
    assign w_gt       = (s_pixel > w_th);
    assign w_sum_next = r_sum + SW'(s_pixel);

    always_comb begin
        w_data = '0;
        case (w_mode)
            MODE_BINARY:     w_data = w_gt ? '1 : '0;
            MODE_BINARY_INV: w_data = w_gt ? '0 : '1;
            MODE_TOZERO:     w_data = w_gt ? s_pixel : '0;
            default:         w_data = w_gt ? w_th : s_pixel;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col      <= '0;
            r_row      <= '0;
            r_sum      <= '0;
            r_mean     <= '0;
            r_mean_vld <= 1'b0;
            r_mode     <= 2'd0;
            r_thresh   <= '0;
            r_auto     <= 1'b0;
            r_m_valid  <= 1'b0;
            r_m_data   <= '0;
            r_m_bit    <= 1'b0;
            r_m_first  <= 1'b0;
            r_m_last   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_m_valid <= 1'b1;
                r_m_data  <= w_data;
                r_m_bit   <= w_gt;
                r_m_first <= w_first;
                r_m_last  <= w_last;

                if (w_first) begin
                    r_mode   <= cfg_mode;
                    r_thresh <= cfg_thresh;
                    r_auto   <= cfg_auto;
                end

                if (w_col_end) begin
                    r_col <= '0;
                    r_row <= w_last ? '0 : r_row + RW'(1);
                end else begin
                    r_col <= r_col + CW'(1);
                end

                // Mean takes effect from the next frame's first pixel.
                if (w_last) begin
                    r_mean     <= w_sum_next[SW-1:LOG_N];
                    r_mean_vld <= 1'b1;
                    r_sum      <= '0;
                end else begin
                    r_sum <= w_sum_next;
                end
            end else if (m_ready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    assign m_valid  = r_m_valid;
    assign m_data   = r_m_data;
    assign m_bit    = r_m_bit;
    assign m_first  = r_m_first;
    assign m_last   = r_m_last;
    assign mean     = r_mean;
    assign mean_vld = r_mean_vld;

endmodule
